demux1_2_16_buf: RTL and testbench

- 1-to-2 steering block: the write-side counterpart of the 16-bit 2:1 select mux.
- Takes one valid/ready source stream and routes each word to output 0 or output 1 by a per-word select bit.
- Each output has its own small FIFO, so a stalled consumer does not block the other destination.
- Used in the single-cycle CPU datapath to fan one result bus out to two sinks, e.g. the register-file write port and the memory write buffer.

---
 rtl/demux1_2_16_buf_if.sv | 34 +++
 rtl/demux1_2_16_buf.sv | 106 ++++++++++
 tb/tb_demux1_2_16_buf.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/demux1_2_16_buf_if.sv
// rtl/demux1_2_16_buf_if.sv - stream bundle for the 1-to-2 buffered demux
// Purpose: groups the source stream and the two destination streams.
// Signals:
//   in_data/in_sel/in_valid  source word, destination select, word present
//   in_ready                 demux accepts the source word this cycle
//   o0_data/o0_valid         head of output FIFO 0
//   o0_ready                 sink 0 accepts head word
//   o1_data/o1_valid         head of output FIFO 1
//   o1_ready                 sink 1 accepts head word
// Modports: master = source and sinks (testbench/datapath), slave = demux.
interface demux1_2_16_buf_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] o0_data;
  logic             o0_valid;
  logic             o0_ready;
  logic [WIDTH-1:0] o1_data;
  logic             o1_valid;
  logic             o1_ready;

  modport master (
    output in_data, in_sel, in_valid, o0_ready, o1_ready,
    input  in_ready, o0_data, o0_valid, o1_data, o1_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, o0_ready, o1_ready,
    output in_ready, o0_data, o0_valid, o1_data, o1_valid
  );
endinterface

// File: rtl/demux1_2_16_buf.sv
// rtl/demux1_2_16_buf.sv - 1-to-2 stream demux with a small FIFO per output
// Purpose: steers each source word to output 0 or 1 by in_sel; each output
//   has its own DEPTH-entry FIFO so a stalled sink does not block the other.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (empties FIFOs, clears storage)
//   bus       demux1_2_16_buf_if.slave: in_* source stream, o0_*/o1_* outputs
//   o0_count  words delivered on output 0 (only with DEMUX_COUNT_EN)
//   o1_count  words delivered on output 1 (only with DEMUX_COUNT_EN)
// Optional feature macro: DEMUX_COUNT_EN (per-output delivered-word counters).
module demux1_2_16_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux1_2_16_buf_if.slave      bus
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0]      o0_count,
  output logic [CNT_W-1:0]      o1_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem    [2][DEPTH];
  logic [AW-1:0]    wr_ptr [2];
  logic [AW-1:0]    rd_ptr [2];
  logic [AW:0]      occ    [2];

  logic [1:0] full;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] oready;
  logic       in_ready_w;

  assign oready = {bus.o1_ready, bus.o0_ready};

  // Acceptance looks only at the selected FIFO; a pop in the same cycle does
  // not free a slot for the push, so a full FIFO always refuses.
  always_comb begin
    full       = '0;
    push       = '0;
    pop        = '0;
    for (int i = 0; i < 2; i++) begin
      full[i] = (occ[i] == FULL_OCC);
      pop[i]  = (occ[i] != '0) & oready[i];
    end
    in_ready_w        = ~full[bus.in_sel];
    push[bus.in_sel]  = bus.in_valid & in_ready_w;
  end

  assign bus.in_ready = in_ready_w;
  assign bus.o0_valid = (occ[0] != '0);
  assign bus.o1_valid = (occ[1] != '0);
  assign bus.o0_data  = mem[0][rd_ptr[0]];
  assign bus.o1_data  = mem[1][rd_ptr[1]];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        occ[i]    <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          mem[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= bus.in_data;
          wr_ptr[i]         <= wr_ptr[i] + 1'b1;
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        end
        if (push[i] && !pop[i]) begin
          occ[i] <= occ[i] + 1'b1;
        end else if (!push[i] && pop[i]) begin
          occ[i] <= occ[i] - 1'b1;
        end
      end
    end
  end

`ifdef DEMUX_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o0_count <= '0;
      o1_count <= '0;
    end else begin
      if (pop[0]) o0_count <= o0_count + 1'b1;
      if (pop[1]) o1_count <= o1_count + 1'b1;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_demux1_2_16_buf.sv
// tb/tb_demux1_2_16_buf.sv - directed self-checking bench for demux1_2_16_buf
module tb_demux1_2_16_buf;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  demux1_2_16_buf_if #(.WIDTH(16)) bus ();

`ifdef DEMUX_COUNT_EN
  logic [15:0] o0_count;
  logic [15:0] o1_count;
  demux1_2_16_buf #(.WIDTH(16), .DEPTH(2), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .o0_count (o0_count),
    .o1_count (o1_count)
  );
`else
  demux1_2_16_buf #(.WIDTH(16), .DEPTH(2), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int rcv;
    int cyc;
    logic acc;
    logic dlv;

    n_cmp = 0;
    n_err = 0;

    // Reset with a word waiting on the source.
    rst_n           = 1'b0;
    bus.in_valid    = 1'b1;
    bus.in_sel      = 1'b0;
    bus.in_data     = 16'h0030;
    bus.o0_ready    = 1'b0;
    bus.o1_ready    = 1'b0;
    step(); step();
    chk("rst_o0_valid", bus.o0_valid, 0);
    chk("rst_o1_valid", bus.o1_valid, 0);
    chk("rst_o0_data",  bus.o0_data,  16'h0000);
    chk("rst_o1_data",  bus.o1_data,  16'h0000);
    chk("rst_in_ready", bus.in_ready, 1);
`ifdef DEMUX_COUNT_EN
    chk("rst_o0_count", o0_count, 0);
    chk("rst_o1_count", o1_count, 0);
`endif
    rst_n = 1'b1;
    step();
    chk("first_o0_valid", bus.o0_valid, 1);
    chk("first_o0_data",  bus.o0_data,  16'h0030);
    chk("first_o1_valid", bus.o1_valid, 0);
    bus.in_valid = 1'b0;
    bus.o0_ready = 1'b1;
    step();
    chk("first_drained", bus.o0_valid, 0);

    // Routing by select bit.
    bus.o0_ready = 1'b1;
    bus.o1_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b0;
    bus.in_data  = 16'h001E;
    step();
    chk("route_o0_valid", bus.o0_valid, 1);
    chk("route_o0_data",  bus.o0_data,  16'h001E);
    chk("route_o1_idle",  bus.o1_valid, 0);
    bus.in_sel  = 1'b1;
    bus.in_data = 16'h0011;
    step();
    chk("route_o0_gone",  bus.o0_valid, 0);
    chk("route_o1_valid", bus.o1_valid, 1);
    chk("route_o1_data",  bus.o1_data,  16'h0011);
    bus.in_valid = 1'b0;
    step();
    chk("route_o1_gone",  bus.o1_valid, 0);

    // Backpressure on output 0 does not block output 1.
    bus.o0_ready = 1'b0;
    bus.o1_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b0;
    bus.in_data  = 16'h0001;
    step();
    bus.in_data  = 16'h0002;
    step();
    chk("bp_full_ready0", bus.in_ready, 0);
    bus.in_sel   = 1'b1;
    bus.in_data  = 16'h0003;
    #1;
    chk("bp_ready_sel1", bus.in_ready, 1);
    step();
    chk("bp_o1_valid", bus.o1_valid, 1);
    chk("bp_o1_data",  bus.o1_data,  16'h0003);
    bus.in_valid = 1'b0;
    bus.o0_ready = 1'b1;
    #1;
    chk("bp_o0_head1", bus.o0_data, 16'h0001);
    step();
    chk("bp_o0_head2", bus.o0_data, 16'h0002);
    chk("bp_o0_valid2", bus.o0_valid, 1);
    step();
    chk("bp_o0_empty", bus.o0_valid, 0);
    bus.o1_ready = 1'b1;
    step();
    chk("bp_o1_empty", bus.o1_valid, 0);

    // Full FIFO with a pop in the same cycle still refuses the push.
    bus.o0_ready = 1'b0;
    bus.o1_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b0;
    bus.in_data  = 16'h0021;
    step();
    bus.in_data  = 16'h0022;
    step();
    bus.in_data  = 16'h0023;
    bus.o0_ready = 1'b1;
    #1;
    chk("fp_refused", bus.in_ready, 0);
    step();
    chk("fp_head22", bus.o0_data, 16'h0022);
    chk("fp_ready_again", bus.in_ready, 1);
    step();
    chk("fp_head23", bus.o0_data, 16'h0023);
    chk("fp_valid23", bus.o0_valid, 1);
    bus.in_valid = 1'b0;
    step();
    chk("fp_empty", bus.o0_valid, 0);

    // Wrap-around: 8 words to output 1 with a toggling sink.
    sent = 0;
    rcv  = 0;
    cyc  = 0;
    bus.o0_ready = 1'b0;
    bus.in_sel   = 1'b1;
    while ((rcv < 8) && (cyc < 100)) begin
      bus.in_valid = (sent < 8);
      bus.in_data  = 16'h0100 + 16'(sent);
      bus.o1_ready = cyc[0];
      #1;
      acc = bus.in_valid & bus.in_ready;
      dlv = bus.o1_valid & bus.o1_ready;
      if (dlv) begin
        chk("wrap_word", bus.o1_data, 16'h0100 + 16'(rcv));
      end
      step();
      if (acc) sent++;
      if (dlv) rcv++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.o1_ready = 1'b0;
    chk("wrap_count", rcv, 8);
    chk("wrap_sent", sent, 8);
    #1;
    chk("wrap_empty", bus.o1_valid, 0);

`ifdef DEMUX_COUNT_EN
    // Delivered-word counter on output 0.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    bus.o0_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b0;
    bus.in_data  = 16'h0041;
    step();
    bus.in_data  = 16'h0042;
    step();
    bus.in_data  = 16'h0043;
    step();
    bus.in_valid = 1'b0;
    step();
    chk("cnt_o0_3", o0_count, 3);
    chk("cnt_o1_0", o1_count, 0);
`endif

    // Asynchronous reset between edges with FIFO 0 full.
    bus.o0_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b0;
    bus.in_data  = 16'h0051;
    step();
    bus.in_data  = 16'h0052;
    step();
    bus.in_valid = 1'b0;
    chk("ar_pre_valid", bus.o0_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid_fell", bus.o0_valid, 0);
    chk("ar_data_zero",  bus.o0_data,  16'h0000);
    chk("ar_in_ready",   bus.in_ready, 1);
`ifdef DEMUX_COUNT_EN
    chk("ar_count_zero", o0_count, 0);
`endif
    #1;
    rst_n = 1'b1;
    bus.o0_ready = 1'b1;
    step();
    chk("ar_post_valid", bus.o0_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
